color_blob_tracker: RTL and testbench

// Downstream consumer of the RGB image ROM stage. Drives the ROM scan coordinates in raster order,

---
 rtl/color_blob_tracker.sv | 236 +++++++++++++++++++++++
 tb/tb_color_blob_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_blob_tracker.sv
// Scans a WIDTH x HEIGHT image in raster order and thresholds each RGB pixel against a colour window.
// It accumulates count, bounding box and coordinate sums, then divides to get the blob centroid.
module color_blob_tracker #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int R_MIN  = 128,
  parameter int R_MAX  = 255,
  parameter int G_MIN  = 0,
  parameter int G_MAX  = 80,
  parameter int B_MIN  = 0,
  parameter int B_MAX  = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  x_img,
  output logic [9:0]  y_img,
  input  logic [7:0]  Rp,
  input  logic [7:0]  Gp,
  input  logic [7:0]  Bp,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [19:0] pixel_count,
  output logic [9:0]  xmin,
  output logic [9:0]  xmax,
  output logic [9:0]  ymin,
  output logic [9:0]  ymax,
  output logic [9:0]  cx,
  output logic [9:0]  cy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_DIV_X = 3'd3,
    S_DIV_Y = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

  state_t state, state_nxt;

  // Pixel pipeline: coordinates driven this cycle come back as RGB one clock later.
  logic        pix_valid;
  logic [9:0]  x_d, y_d;

  logic [19:0] cnt, cnt_nxt;
  logic [31:0] sx, sx_nxt, sy, sy_nxt;
  logic [9:0]  bx0, bx0_nxt, bx1, bx1_nxt, by0, by0_nxt, by1, by1_nxt;

  logic [31:0] q, q_step;
  logic [20:0] rem, rem_step;
  logic [21:0] shifted;
  logic        ge;
  logic [4:0]  step;
  logic [9:0]  cx_q;

  logic start_acc, scan_last, div_last, pix_match;

  assign start_acc = (state == S_IDLE) && start;
  assign scan_last = (x_img == X_LAST) && (y_img == Y_LAST);
  assign div_last  = (step == 5'd31);

  assign pix_match = pix_valid &&
                     int'(Rp) >= R_MIN && int'(Rp) <= R_MAX &&
                     int'(Gp) >= G_MIN && int'(Gp) <= G_MAX &&
                     int'(Bp) >= B_MIN && int'(Bp) <= B_MAX;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (scan_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = (cnt_nxt == 20'd0) ? S_DONE : S_DIV_X;
      S_DIV_X: if (div_last) state_nxt = S_DIV_Y;
      S_DIV_Y: if (div_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Accumulator update for the pixel currently returned by the ROM stage.
  always_comb begin
    cnt_nxt = cnt;
    sx_nxt  = sx;
    sy_nxt  = sy;
    bx0_nxt = bx0;
    bx1_nxt = bx1;
    by0_nxt = by0;
    by1_nxt = by1;
    if (pix_match) begin
      cnt_nxt = cnt + 20'd1;
      sx_nxt  = sx + 32'(x_d);
      sy_nxt  = sy + 32'(y_d);
      if (cnt == 20'd0) begin
        bx0_nxt = x_d;
        bx1_nxt = x_d;
        by0_nxt = y_d;
        by1_nxt = y_d;
      end else begin
        if (x_d < bx0) bx0_nxt = x_d;
        if (x_d > bx1) bx1_nxt = x_d;
        if (y_d < by0) by0_nxt = y_d;
        if (y_d > by1) by1_nxt = y_d;
      end
    end
  end

  // One restoring-division step; the remainder is always below the 20-bit divisor.
  always_comb begin
    shifted  = {rem, q[31]};
    ge       = (shifted >= {2'b00, cnt});
    rem_step = ge ? 21'(shifted - {2'b00, cnt}) : 21'(shifted);
    q_step   = {q[30:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_img       <= '0;
      y_img       <= '0;
      pix_valid   <= 1'b0;
      x_d         <= '0;
      y_d         <= '0;
      cnt         <= '0;
      sx          <= '0;
      sy          <= '0;
      bx0         <= '0;
      bx1         <= '0;
      by0         <= '0;
      by1         <= '0;
      q           <= '0;
      rem         <= '0;
      step        <= '0;
      cx_q        <= '0;
      found       <= 1'b0;
      pixel_count <= '0;
      xmin        <= '0;
      xmax        <= '0;
      ymin        <= '0;
      ymax        <= '0;
      cx          <= '0;
      cy          <= '0;
    end else begin
      pix_valid <= (state == S_SCAN);
      x_d       <= x_img;
      y_d       <= y_img;

      if (state == S_SCAN && !scan_last) begin
        if (x_img == X_LAST) begin
          x_img <= '0;
          y_img <= y_img + 10'd1;
        end else begin
          x_img <= x_img + 10'd1;
        end
      end else begin
        x_img <= '0;
        y_img <= '0;
      end

      if (start_acc) begin
        cnt <= '0;
        sx  <= '0;
        sy  <= '0;
        bx0 <= '0;
        bx1 <= '0;
        by0 <= '0;
        by1 <= '0;
      end else begin
        cnt <= cnt_nxt;
        sx  <= sx_nxt;
        sy  <= sy_nxt;
        bx0 <= bx0_nxt;
        bx1 <= bx1_nxt;
        by0 <= by0_nxt;
        by1 <= by1_nxt;
      end

      // DRAIN loads the X dividend including the last pixel's contribution.
      if (state == S_DRAIN) begin
        q    <= sx_nxt;
        rem  <= '0;
        step <= '0;
      end else if (state == S_DIV_X || state == S_DIV_Y) begin
        step <= step + 5'd1;
        if (state == S_DIV_X && div_last) begin
          cx_q <= q_step[9:0];
          q    <= sy;
          rem  <= '0;
        end else begin
          q   <= q_step;
          rem <= rem_step;
        end
      end

      if (start_acc || (state == S_DRAIN && cnt_nxt == 20'd0)) begin
        found       <= 1'b0;
        pixel_count <= '0;
        xmin        <= '0;
        xmax        <= '0;
        ymin        <= '0;
        ymax        <= '0;
        cx          <= '0;
        cy          <= '0;
      end else if (state == S_DIV_Y && div_last) begin
        found       <= 1'b1;
        pixel_count <= cnt;
        xmin        <= bx0;
        xmax        <= bx1;
        ymin        <= by0;
        ymax        <= by1;
        cx          <= cx_q;
        cy          <= q_step[9:0];
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Bench for color_blob_tracker on a 4x4 image with a registered ROM model feeding RGB back.
module tb_color_blob_tracker;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int RW = 81;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  x_img, y_img;
  logic [7:0]  Rp, Gp, Bp;
  logic        busy, done, found;
  logic [19:0] pixel_count;
  logic [9:0]  xmin, xmax, ymin, ymax, cx, cy;
  logic [2:0]  state_dbg;

  logic [23:0] img [W*H];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    int            kind;
    int            pulse_a;
    int            pulse_b;
    bit            scan_chk;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  color_blob_tracker #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_img(x_img), .y_img(y_img),
    .Rp(Rp), .Gp(Gp), .Bp(Bp),
    .busy(busy), .done(done), .found(found), .pixel_count(pixel_count),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .cx(cx), .cy(cy), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // ROM stage model: RGB registered one clock after the coordinates.
  always @(posedge clk) {Rp, Gp, Bp} <= img[{y_img[1:0], x_img[1:0]}];

  function automatic logic [RW-1:0] pack(input bit f, input int c, input int x0, input int x1,
                                         input int y0, input int y1, input int ccx, input int ccy);
    return {f, 20'(c), 10'(x0), 10'(x1), 10'(y0), 10'(y1), 10'(ccx), 10'(ccy)};
  endfunction

  function automatic logic [RW-1:0] actual_res();
    return {found, pixel_count, xmin, xmax, ymin, ymax, cx, cy};
  endfunction

  // Reference model of one frame over the current image.
  function automatic logic [RW-1:0] model();
    int c = 0, sxx = 0, syy = 0, x0 = 0, x1 = 0, y0 = 0, y1 = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [23:0] p;
        p = img[y*W + x];
        if (p[23:16] >= 8'd128 && p[15:8] <= 8'd80 && p[7:0] <= 8'd80) begin
          if (c == 0) begin x0 = x; x1 = x; y0 = y; y1 = y; end
          else begin
            if (x < x0) x0 = x;
            if (x > x1) x1 = x;
            if (y < y0) y0 = y;
            if (y > y1) y1 = y;
          end
          c++; sxx += x; syy += y;
        end
      end
    end
    if (c == 0) return '0;
    return pack(1'b1, c, x0, x1, y0, y1, sxx / c, syy / c);
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_image(input int kind);
    for (int i = 0; i < W*H; i++) img[i] = 24'h000000;
    case (kind)
      1: img[6] = 24'hFF0000;
      2: begin img[5] = 24'hFF0000; img[6] = 24'hFF0000; img[9] = 24'hFF0000; img[10] = 24'hFF0000; end
      3: for (int i = 0; i < W*H; i++) img[i] = 24'hFF0000;
      4: begin
        img[0]  = {8'd127, 8'd0,  8'd0};
        img[11] = {8'd128, 8'd80, 8'd80};
        img[13] = {8'd128, 8'd81, 8'd0};
        img[2]  = {8'd255, 8'd80, 8'd81};
      end
      5: for (int i = 0; i < W*H; i++)
           img[i] = {8'($urandom_range(120, 255)), 8'($urandom_range(0, 90)), 8'($urandom_range(0, 90))};
      default: ;
    endcase
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        chk("result", actual_res(), exp_q.pop_front());
      end
    end
  end

  // Runs one frame; start is sampled at E0 and k counts negedges after E_k.
  task automatic run_frame(input logic [RW-1:0] e, input int pulse_a, input int pulse_b, input bit scan_chk);
    int lat, got, dc0;
    lat = e[RW-1] ? W*H + 65 : W*H + 1;
    got = -1;
    dc0 = done_cnt;
    exp_q.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("cleared_on_start", RW'(pixel_count), RW'(0));
    for (int k = 0; k < 400; k++) begin
      if (scan_chk && k <= W*H)
        chk("scan_xy", RW'({x_img, y_img}),
            k < W*H ? RW'({10'(k % W), 10'(k / W)}) : RW'(0));
      if (done) begin got = k; break; end
      start = (k == pulse_a || k == pulse_b);
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", RW'(got), RW'(lat));
    @(negedge clk);
    chk("busy_done_after", RW'({busy, done}), RW'(0));
    chk("results_hold", actual_res(), e);
    repeat ((pulse_a >= 0 || pulse_b >= 0) ? 120 : 5) @(negedge clk);
    chk("done_count", RW'(done_cnt - dc0), RW'(1));
  endtask

  initial begin
    int k, got1, got2;
    logic [RW-1:0] e;

    vecs[0] = '{0, -1, -1, 1'b1, pack(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{1, -1, -1, 1'b0, pack(1, 1, 2, 2, 1, 1, 2, 1)};
    vecs[2] = '{2, -1, -1, 1'b0, pack(1, 4, 1, 2, 1, 2, 1, 1)};
    vecs[3] = '{3,  5, 40, 1'b0, pack(1, 16, 0, 3, 0, 3, 1, 1)};
    vecs[4] = '{4, -1, -1, 1'b0, pack(1, 1, 3, 3, 2, 2, 3, 2)};

    rst = 1'b1; start = 1'b0;
    set_image(0);
    repeat (3) @(negedge clk);
    chk("reset_results", actual_res(), '0);
    chk("reset_ctrl", RW'({busy, done, x_img, y_img}), RW'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table of directed frames
    for (int i = 0; i < 5; i++) begin
      set_image(vecs[i].kind);
      run_frame(vecs[i].exp, vecs[i].pulse_a, vecs[i].pulse_b, vecs[i].scan_chk);
    end

    // Random images against the model
    for (int i = 0; i < 3; i++) begin
      set_image(5);
      run_frame(model(), -1, -1, 1'b0);
    end

    // Reset mid-frame: sampled at E8, no done, outputs cleared
    set_image(2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_results", actual_res(), '0);
    chk("midreset_ctrl", RW'({busy, done, x_img, y_img}), RW'(0));
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midreset_idle", RW'(busy), RW'(0));
    run_frame(pack(1, 4, 1, 2, 1, 2, 1, 1), -1, -1, 1'b0);

    // Start held high re-triggers in the cycle after DONE
    set_image(0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    got1 = -1; got2 = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    k = 0;
    while (k < 200 && got2 < 0) begin
      if (done && got1 < 0) got1 = k;
      else if (done) got2 = k;
      if (got1 >= 0 && k == got1 + 1) chk("retrig_idle", RW'(busy), RW'(0));
      if (got1 >= 0 && k == got1 + 2) begin
        chk("retrig_busy", RW'(busy), RW'(1));
        start = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("retrig_first", RW'(got1), RW'(17));
    chk("retrig_second", RW'(got2), RW'(36));
    repeat (5) @(negedge clk);

    chk("queue_empty", RW'(exp_q.size()), RW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
